// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller between decode and the execute/writeback
//   datapath. A DEPTH-entry scoreboard tracks in-flight destination registers
//   (entry 0 youngest, entry DEPTH-1 retires next). For each decode operand the
//   youngest matching entry selects the forwarding source. Loads younger than
//   LOAD_LAT stages produce a load-use stall (a bubble enters the scoreboard).
//   A redirect from execute squashes KILL_SLOTS decode slots, counting the
//   redirect cycle itself.
//
// Ports
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   dec_valid    dec_inst holds a valid instruction
//   dec_inst     instruction in decode
//   ex_redirect  taken branch / JALR resolved in execute this cycle
//   stall_ext    external freeze; scoreboard and kill FSM hold
//   issue_valid  decode instruction advances this cycle
//   stall        hold PC and decode register
//   flush        decode slot squashed this cycle
//   fwd_a/fwd_b  operand source: 0 = regfile, k = scoreboard entry k-1
//   stall_cnt    (HAZARD_CTRL_PERF_EN) saturating count of internal stall cycles
//   flush_cnt    (HAZARD_CTRL_PERF_EN) saturating count of flush cycles
//
// Build option: define HAZARD_CTRL_PERF_EN to add the performance counters.
module hazard_ctrl #(
  parameter int DEPTH      = 2,
  parameter int LOAD_LAT   = 1,
  parameter int KILL_SLOTS = 1,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec_valid,
  input  logic [31:0]   dec_inst,
  input  logic          ex_redirect,
  input  logic          stall_ext,
  output logic          issue_valid,
  output logic          stall,
  output logic          flush,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  localparam int CNT_W = 4;

  typedef enum logic {RUN, KILL} state_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       rd_wr, rs1_use, rs2_use, is_load;
  logic       unused_bits;

  assign opcode      = dec_inst[6:0];
  assign rd          = dec_inst[11:7];
  assign funct3      = dec_inst[14:12];
  assign rs1         = dec_inst[19:15];
  assign rs2         = dec_inst[24:20];
  assign unused_bits = ^dec_inst[31:25];
  assign is_load     = (opcode == 7'h03);

  always_comb begin
    rd_wr   = 1'b0;
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    case (opcode)
      7'h33: begin rd_wr = 1'b1; rs1_use = 1'b1; rs2_use = 1'b1; end
      7'h13,
      7'h03,
      7'h67: begin rd_wr = 1'b1; rs1_use = 1'b1; end
      7'h37,
      7'h17,
      7'h6F: rd_wr = 1'b1;
      7'h23,
      7'h63: begin rs1_use = 1'b1; rs2_use = 1'b1; end
      // SYSTEM: CSR ops write rd; the immediate forms (funct3[2]=1) read no rs1
      7'h73: begin rd_wr = (funct3 != 3'd0); rs1_use = ~funct3[2]; end
      default: ;
    endcase
    // x0 is never tracked, so a zero rd is not a writer
    if (rd == 5'd0) rd_wr = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] sb_v_q, sb_v_d;
  logic [DEPTH-1:0] sb_ld_q, sb_ld_d;
  logic [4:0]       sb_rd_q [DEPTH];
  logic [4:0]       sb_rd_d [DEPTH];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Youngest-match lookup; returns {load-use hit, forward select}.
  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  function automatic logic [FW:0] lookup(input logic [4:0]       rs,
                                         input logic             used,
                                         input logic [DEPTH-1:0] v,
                                         input logic [DEPTH-1:0] ld,
                                         input logic [4:0]       rdv [DEPTH]);
    logic [FW-1:0] sel;
    logic          lu;
    sel = '0;
    lu  = 1'b0;
    if (used && (rs != 5'd0)) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (v[i] && (rdv[i] == rs)) begin
          sel = FW'(i + 1);
          lu  = ld[i] && (i < LOAD_LAT);
        end
      end
    end
    return {lu, sel};
  endfunction

  logic [FW:0] look_a, look_b;
  logic        load_use;

  assign look_a   = lookup(rs1, rs1_use, sb_v_q, sb_ld_q, sb_rd_q);
  assign look_b   = lookup(rs2, rs2_use, sb_v_q, sb_ld_q, sb_rd_q);
  assign load_use = look_a[FW] | look_b[FW];

  // ---------------------------------------------------------------------------
  // Outputs (combinational, reset-qualified)
  // ---------------------------------------------------------------------------
  assign flush       = rst_n && !stall_ext && (ex_redirect || (state_q == KILL));
  assign stall       = stall_ext || (rst_n && !flush && load_use);
  assign issue_valid = rst_n && dec_valid && !stall && !flush;
  assign fwd_a       = rst_n ? look_a[FW-1:0] : '0;
  assign fwd_b       = rst_n ? look_b[FW-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Scoreboard next state: shift on advance; a non-issuing slot (stall bubble,
  // flush, invalid decode) enters as an invalid entry
  // ---------------------------------------------------------------------------
  always_comb begin
    sb_v_d  = sb_v_q;
    sb_ld_d = sb_ld_q;
    sb_rd_d = sb_rd_q;
    if (!stall_ext) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb_v_d[i]  = sb_v_q[i-1];
        sb_ld_d[i] = sb_ld_q[i-1];
        sb_rd_d[i] = sb_rd_q[i-1];
      end
      sb_v_d[0]  = issue_valid && rd_wr;
      sb_ld_d[0] = is_load;
      sb_rd_d[0] = rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_q  <= '0;
      sb_ld_q <= '0;
      for (int i = 0; i < DEPTH; i++) sb_rd_q[i] <= '0;
    end else begin
      sb_v_q  <= sb_v_d;
      sb_ld_q <= sb_ld_d;
      sb_rd_q <= sb_rd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Kill FSM: cnt holds the number of squash slots still owed after this one.
  // The redirect cycle is the first squashed slot, so KILL covers the rest.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall_ext) begin
      if (ex_redirect) begin
        state_d = (KILL_SLOTS > 1) ? KILL : RUN;
        cnt_d   = CNT_W'(KILL_SLOTS - 1);
      end else if (state_q == KILL) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !stall_ext && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Counters absent in this build; no additional state.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (DEPTH=2, LOAD_LAT=1, KILL_SLOTS=3).
// A queue-based reference model tracks in-flight writers and the number of
// owed squash slots; every cycle the DUT outputs are compared against it.
module tb_hazard_ctrl;

  localparam int DEPTH      = 2;
  localparam int LOAD_LAT   = 1;
  localparam int KILL_SLOTS = 3;
  localparam int FW         = $clog2(DEPTH + 1);
  localparam int OW         = 3 + 2 * FW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dec_valid = 1'b0;
  logic [31:0]   dec_inst = NOP;
  logic          ex_redirect = 1'b0;
  logic          stall_ext = 1'b0;
  logic          issue_valid, stall, flush;
  logic [FW-1:0] fwd_a, fwd_b;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .KILL_SLOTS(KILL_SLOTS)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_inst(dec_inst),
    .ex_redirect(ex_redirect), .stall_ext(stall_ext),
    .issue_valid(issue_valid), .stall(stall), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct { bit v; logic [4:0] rd; bit ld; } ent_t;
  typedef struct { bit rn; bit dv; logic [31:0] inst; bit r; bit sx; } step_t;

  ent_t        sb[$];
  int          kill_rem;
  logic [31:0] m_scnt, m_fcnt;
  logic        exp_iv, exp_st, exp_fl;
  logic [FW-1:0] exp_fa, exp_fb;
  logic [OW-1:0] exp_out;

  function automatic logic [31:0] r_type(input logic [4:0] rd, rs1, rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_type(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, rs1);
    return {12'd0, rs1, f3, rd, op};
  endfunction

  function automatic bit writes(input logic [31:0] in);
    logic [6:0] op = in[6:0];
    bit w;
    w = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h37) ||
        (op == 7'h17) || (op == 7'h6F) || (op == 7'h67) ||
        ((op == 7'h73) && (in[14:12] != 3'd0));
    return w && (in[11:7] != 5'd0);
  endfunction
  function automatic bit uses1(input logic [31:0] in);
    logic [6:0] op = in[6:0];
    return (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) ||
           (op == 7'h63) || (op == 7'h67) || ((op == 7'h73) && !in[14]);
  endfunction
  function automatic bit uses2(input logic [31:0] in);
    logic [6:0] op = in[6:0];
    return (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
  endfunction

  // Position (1-based) of the youngest in-flight writer of r, or 0.
  function automatic int find_src(input logic [4:0] r, input bit used);
    int k = 0;
    if (used && r != 5'd0)
      foreach (sb[i]) if (k == 0 && sb[i].v && sb[i].rd == r) k = i + 1;
    return k;
  endfunction

  function automatic bit is_lu(input int k);
    return (k > 0) && sb[k-1].ld && ((k - 1) < LOAD_LAT);
  endfunction

  function automatic void model_reset();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) sb.push_back('{v: 1'b0, rd: 5'd0, ld: 1'b0});
    kill_rem = 0;
    m_scnt   = 0;
    m_fcnt   = 0;
  endfunction

  function automatic void model_eval();
    int ka, kb;
    if (!rst_n) begin
      exp_iv = 0; exp_fl = 0; exp_st = stall_ext; exp_fa = 0; exp_fb = 0;
    end else begin
      ka     = find_src(dec_inst[19:15], uses1(dec_inst));
      kb     = find_src(dec_inst[24:20], uses2(dec_inst));
      exp_fa = FW'(ka);
      exp_fb = FW'(kb);
      exp_fl = !stall_ext && (ex_redirect || kill_rem > 0);
      exp_st = stall_ext || (!exp_fl && (is_lu(ka) || is_lu(kb)));
      exp_iv = dec_valid && !exp_st && !exp_fl;
    end
    exp_out = {exp_iv, exp_st, exp_fl, exp_fa, exp_fb};
  endfunction

  function automatic void model_update();
    ent_t e;
    if (!rst_n) return;
    if (exp_st && !stall_ext) m_scnt++;
    if (exp_fl) m_fcnt++;
    if (stall_ext) return;
    e.v  = exp_iv && writes(dec_inst);
    e.rd = dec_inst[11:7];
    e.ld = (dec_inst[6:0] == 7'h03);
    sb.push_front(e);
    void'(sb.pop_back());
    if (ex_redirect) kill_rem = KILL_SLOTS - 1;
    else if (kill_rem > 0) kill_rem--;
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {issue_valid, stall, flush, fwd_a, fwd_b};
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    rst_n = s.rn;
    if (!s.rn) model_reset();
    dec_valid = s.dv; dec_inst = s.inst; ex_redirect = s.r; stall_ext = s.sx;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  function automatic step_t st(input bit dv, input logic [31:0] inst,
                               input bit r = 0, input bit sx = 0, input bit rn = 1);
    return '{rn: rn, dv: dv, inst: inst, r: r, sx: sx};
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      drive(st(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'b0));
      n_vec++;
      if (dut_out() !== exp_out || exp_iv || exp_fl || exp_fa != 0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: got %b want %b", k, dut_out(), exp_out);
      end
      tick();
    end
`ifdef HAZARD_CTRL_PERF_EN
    n_vec++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_forward();
    int    want [3] = '{1, 2, 0};
    step_t prog[$];
    for (int g = 0; g < 3; g++) begin
      prog = {st(1, NOP), st(1, NOP), st(1, i_type(7'h13, 3'd0, 5'd5, 5'd0))};
      for (int n = 0; n < g; n++) prog.push_back(st(1, NOP));
      prog.push_back(st(1, r_type(5'd6, 5'd5, 5'd5)));
      foreach (prog[j]) begin
        drive(prog[j]);
        n_vec++;
        if (dut_out() !== exp_out) begin
          n_fail++;
          $display("FAIL forward_g%0d c%0d: got %b want %b", g, j, dut_out(), exp_out);
        end
        if (j == prog.size() - 1) begin
          n_vec++;
          if (fwd_a !== FW'(want[g]) || fwd_b !== FW'(want[g]) || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL forward_gap%0d: got fa=%0d fb=%0d st=%b want fa=fb=%0d st=0",
                     g, fwd_a, fwd_b, stall, want[g]);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_load_use();
    step_t prog[$];
    prog = {st(1, NOP), st(1, NOP), st(1, i_type(7'h03, 3'd2, 5'd7, 5'd1)),
            st(1, r_type(5'd8, 5'd7, 5'd0)), st(1, r_type(5'd8, 5'd7, 5'd0)),
            st(1, r_type(5'd9, 5'd8, 5'd7))};
    foreach (prog[j]) begin
      drive(prog[j]);
      n_vec++;
      if (dut_out() !== exp_out) begin
        n_fail++;
        $display("FAIL load_use c%0d: got %b want %b", j, dut_out(), exp_out);
      end
      if (j == 3) begin
        n_vec++;
        if (stall !== 1'b1 || issue_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL load_use_stall: got st=%b iv=%b want st=1 iv=0", stall, issue_valid);
        end
      end
      if (j == 4) begin
        n_vec++;
        if (stall !== 1'b0 || fwd_a !== FW'(2) || issue_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL load_use_release: got st=%b fa=%0d iv=%b want st=0 fa=2 iv=1",
                   stall, fwd_a, issue_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_kill();
    int want [2] = '{3, 4};
    int nfl;
    for (int sc = 0; sc < 2; sc++) begin
      nfl = 0;
      for (int c = 0; c < 8; c++) begin
        drive(st(1, r_type(5'd9, 5'd1, 5'd2), (c == 2) || (sc == 1 && c == 3)));
        n_vec++;
        if (dut_out() !== exp_out) begin
          n_fail++;
          $display("FAIL kill_s%0d c%0d: got %b want %b", sc, c, dut_out(), exp_out);
        end
        if (flush) nfl++;
        tick();
      end
      n_vec++;
      if (nfl != want[sc]) begin
        n_fail++;
        $display("FAIL kill_count_s%0d: got %0d flush cycles want %0d", sc, nfl, want[sc]);
      end
    end
  endtask

  task automatic test_stall_ext();
    step_t prog[$];
    prog = {st(1, NOP), st(1, NOP), st(1, i_type(7'h13, 3'd0, 5'd5, 5'd0))};
    for (int n = 0; n < 5; n++) prog.push_back(st(1, r_type(5'd6, 5'd5, 5'd5), 0, 1));
    prog.push_back(st(1, r_type(5'd6, 5'd5, 5'd5)));
    prog.push_back(st(1, r_type(5'd7, 5'd6, 5'd5)));
    foreach (prog[j]) begin
      drive(prog[j]);
      n_vec++;
      if (dut_out() !== exp_out) begin
        n_fail++;
        $display("FAIL stall_ext c%0d: got %b want %b", j, dut_out(), exp_out);
      end
      if (j >= 3 && j <= 8) begin
        n_vec++;
        if (fwd_a !== FW'(1) || fwd_b !== FW'(1) || stall !== (j < 8)) begin
          n_fail++;
          $display("FAIL stall_ext_hold c%0d: got fa=%0d fb=%0d st=%b want fa=fb=1 st=%b",
                   j, fwd_a, fwd_b, stall, j < 8);
        end
      end
      tick();
    end
  endtask

  task automatic test_x0();
    step_t prog[$];
    prog = {st(1, NOP), st(1, NOP), st(1, r_type(5'd0, 5'd1, 5'd2)),
            st(1, r_type(5'd3, 5'd0, 5'd0)), st(1, r_type(5'd4, 5'd0, 5'd3))};
    foreach (prog[j]) begin
      drive(prog[j]);
      n_vec++;
      if (dut_out() !== exp_out) begin
        n_fail++;
        $display("FAIL x0 c%0d: got %b want %b", j, dut_out(), exp_out);
      end
      if (j == 3) begin
        n_vec++;
        if (fwd_a !== '0 || fwd_b !== '0) begin
          n_fail++;
          $display("FAIL x0_fwd: got fa=%0d fb=%0d want 0/0", fwd_a, fwd_b);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    step_t prog[$];
    prog = {st(1, NOP), st(1, NOP), st(1, i_type(7'h13, 3'd0, 5'd5, 5'd0)),
            st(1, r_type(5'd6, 5'd5, 5'd5), 1),
            st(1, r_type(5'd6, 5'd5, 5'd5), 0, 0, 0),
            st(1, r_type(5'd6, 5'd5, 5'd5), 1, 1, 0),
            st(1, r_type(5'd6, 5'd5, 5'd5))};
    foreach (prog[j]) begin
      drive(prog[j]);
      n_vec++;
      if (dut_out() !== exp_out) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %b want %b", j, dut_out(), exp_out);
      end
      if (j >= 4) begin
        n_vec++;
        if (flush !== 1'b0 || fwd_a !== '0 || issue_valid !== (j == 6)) begin
          n_fail++;
          $display("FAIL reset_mid_state c%0d: got fl=%b fa=%0d iv=%b want fl=0 fa=0 iv=%b",
                   j, flush, fwd_a, issue_valid, j == 6);
        end
      end
`ifdef HAZARD_CTRL_PERF_EN
      if (j == 4) begin
        n_vec++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_mid_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
    logic [2:0]  f3s [3]  = '{3'd0, 3'd1, 3'd5};
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] inst;
    for (int c = 0; c < 800; c++) begin
      op   = ops[$urandom_range(0, 10)];
      f3   = (op == 7'h73) ? f3s[$urandom_range(0, 2)] : 3'($urandom);
      inst = {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
              5'($urandom_range(0, 3)), op};
      drive(st($urandom_range(0, 7) != 0, inst, $urandom_range(0, 9) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0));
      n_vec++;
      if (dut_out() !== exp_out) begin
        n_fail++;
        $display("FAIL random c%0d inst=%h: got %b want %b", c, inst, dut_out(), exp_out);
      end
      tick();
    end
`ifdef HAZARD_CTRL_PERF_EN
    #1;
    n_vec++;
    if (stall_cnt !== m_scnt || flush_cnt !== m_fcnt) begin
      n_fail++;
      $display("FAIL perf_counters: got %0d/%0d want %0d/%0d",
               stall_cnt, flush_cnt, m_scnt, m_fcnt);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_load_use();
    test_kill();
    test_stall_ext();
    test_x0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the RISC-V core pipeline, sitting between decode and the execute/writeback datapath. It tracks in-flight destination registers in a DEPTH-entry scoreboard and selects the forwarding source for each decode operand. It inserts load-use bubbles and squashes a configurable number of wrong-path slots after a redirect. It generalises the fixed two-stage forwarding decode of the current core to arbitrary pipeline depth and load latency.

## Interface
- DEPTH, 2, in-flight stages after decode that can forward (1..7)
- LOAD_LAT, 1, stages a load needs before its data can forward (0..DEPTH)
- KILL_SLOTS, 1, decode slots squashed per redirect (1..15)
- FW, $clog2(DEPTH+1), width of forward selects (derived, do not override)

- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- dec_valid  in  1  dec_inst holds a valid instruction
- dec_inst  in  32  instruction in decode
- ex_redirect  in  1  taken branch or JALR resolved in X this cycle
- stall_ext  in  1  external freeze (memory not ready)
- issue_valid  out  1  decode instruction advances this cycle
- stall  out  1  hold PC and decode register
- flush  out  1  decode slot squashed this cycle
- fwd_a  out  FW  rs1 source: 0 = regfile, k = scoreboard entry k-1
- fwd_b  out  FW  rs2 source, same encoding

## Operation
- Decode classes by opcode:
  - rd-writer: 0x33, 0x13, 0x03, 0x37, 0x17, 0x6F, 0x67, and 0x73 with func3≠0. Only when rd≠0.
  - rs1-user: 0x33, 0x13, 0x03, 0x23, 0x63, 0x67, and 0x73 with func3[2]=0.
  - rs2-user: 0x33, 0x23, 0x63.
- Scoreboard entry i holds {v, rd[4:0], ld}. Entry 0 is youngest; entry DEPTH-1 retires next cycle.
- Forwarding for fwd_a (fwd_b identical on rs2):
  - If rs1 is used and nonzero, select k = i+1 for the smallest i with v && rd==rs1.
  - Otherwise select 0.
  - The youngest match always wins.
- Load-use: stall when the youngest match for a used operand has ld=1 and i < LOAD_LAT.
- Kill FSM:
  - States: RUN and KILL(cnt).
  - ex_redirect takes the FSM to KILL with cnt=KILL_SLOTS-1; if KILL_SLOTS=1, it stays in RUN. The redirect cycle itself is always flushed.
  - KILL: flush=1 each advancing cycle, cnt decrements, and the FSM returns to RUN after the cnt=0 slot.
  - A redirect while in KILL reloads cnt.
- Output precedence:
  - stall_ext=1 gives stall=1; scoreboard and FSM hold.
  - Else redirect or KILL gives flush=1, stall=0.
  - Else load-use gives stall=1.
  - Else normal.
- issue_valid = dec_valid && !stall && !flush.
- Advance (stall_ext=0): entries shift i→i+1 and entry DEPTH-1 is dropped. Entry 0 loads {1, rd, opcode==0x03} when issue_valid && rd-writer, else loads invalid. A load-use stall therefore inserts a bubble.
- When a redirect occurs, entries already in the scoreboard are not cleared; they are older, committed instructions.

## Timing
- fwd_a, fwd_b, stall, flush and issue_valid are combinational from dec_inst, inputs and registered state. There is no added latency.
- Scoreboard and FSM update on the rising edge of clk.
- Reset (asynchronous assert, synchronous deassert by the top level):
  - All entries invalid, FSM in RUN, performance counters zero.
  - Outputs during reset: fwd_a=fwd_b=0, flush=0, stall=stall_ext, issue_valid=0.
- Boundaries:
  - Reset mid-KILL returns to RUN immediately.
  - A match only in entry DEPTH-1 forwards k=DEPTH in its final cycle, then falls back to 0.
  - rs1==rs2 gives fwd_a==fwd_b.
  - LOAD_LAT=0 never stalls.
  - A load-use stall lasts at most LOAD_LAT cycles per dependency.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - Adds ports stall_cnt out 32 and flush_cnt out 32.
  - The counters count cycles with (stall && !stall_ext) and with flush respectively.
  - They saturate at 0xFFFFFFFF and are cleared by rst_n.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

## Test plan
- DEPTH=2, LOAD_LAT=1:
  - addi x5,x0,1 then add x6,x5,x5 back-to-back -> fwd_a=fwd_b=1, stall=0.
  - Same pair separated by one nop -> fwd=2.
  - Separated by two nops -> fwd=0.
- lw x7,0(x1) then add x8,x7,x0 -> exactly one stall cycle with issue_valid=0. Next cycle: fwd_a=2, stall=0; scoreboard entry 0 is the bubble.
- KILL_SLOTS=3, ex_redirect pulsed one cycle -> flush=1 for 3 consecutive advancing cycles with issue_valid=0. A second redirect in cycle 2 extends flush to 4 total cycles.
- stall_ext=1 for 5 cycles during a dependency chain -> stall=1 and scoreboard unchanged. Forwarding resumes with identical fwd values after release.
- Instructions using x0, e.g. add x0,x1,x2 then add x3,x0,x0 -> no scoreboard entry written, fwd_a=0.
- rst_n asserted mid-KILL and mid-chain -> all outputs at reset values immediately. With HAZARD_CTRL_PERF_EN, stall_cnt=flush_cnt=0.
